// File: rtl/usb_burst_cache.sv
// usb_burst_cache: ring-buffer cache between the USB3 slave-FIFO read path
// and the DA output RAMs. Words arrive one per cycle. Each falling edge of
// the USB FIFO flag plays out a BURST_LEN-word burst of the oldest words.
// Optional macro: CACHE_STATUS_EN enables sticky overflow/underrun status.
// Ports:
//   clock, rst_n          sole clock, synchronous active-low reset
//   wr_data, wr_en        word in from the USB read path
//   usb_flag              asynchronous FIFO flag, falling edge = burst
//   rd_data, rd_valid     playout word and its qualifier
//   wren_for_ram          all ones during each burst data slot
//   fill_level, busy      occupancy and burst-in-progress
//   overflow, underrun    sticky status (0 when CACHE_STATUS_EN undefined)
module usb_burst_cache #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int BURST_LEN = 255,
    parameter int NUM_CH    = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              usb_flag,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] wren_for_ram,
    output logic [ADDR_W:0]   fill_level,
    output logic              busy,
    output logic              overflow,
    output logic              underrun
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] slot_cnt;
    logic [1:0]      state;
    logic            s1, s2, s3;
    logic            fall;
    logic            full;
    logic            empty;
    logic            in_burst;
    logic            rd_issue;
    logic            wr_accept;
    logic            last_slot;

    // The wrap bit makes the subtraction exact for 0..DEPTH.
    assign fill_level = wr_ptr - rd_ptr;
    assign full       = (fill_level == (ADDR_W+1)'(DEPTH));
    assign empty      = (wr_ptr == rd_ptr);
    assign in_burst   = (state == S_BURST);
    assign rd_issue   = in_burst & ~empty;
    // A same-cycle read frees the slot, so a full cache still accepts.
    assign wr_accept  = wr_en & (~full | rd_issue);
    assign fall       = s3 & ~s2;
    assign last_slot  = (slot_cnt == (ADDR_W+1)'(BURST_LEN - 1));
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (rst_n && wr_accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Reset to 1 so a low flag at reset release is not taken as an edge.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= usb_flag;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            slot_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state    <= S_BURST;
                        slot_cnt <= '0;
                    end
                end
                S_BURST: begin
                    if (last_slot) state <= S_DONE;
                    else           slot_cnt <= slot_cnt + 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered read port; rd_data holds across empty slots.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            wren_for_ram <= '0;
        end else begin
            wren_for_ram <= in_burst ? '1 : '0;
            rd_valid     <= rd_issue;
            if (rd_issue) rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

`ifdef CACHE_STATUS_EN
    logic ovf_q;
    logic und_q;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            und_q <= 1'b0;
        end else begin
            if (wr_en && full && !rd_issue) ovf_q <= 1'b1;
            if (in_burst && empty)          und_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
    assign underrun = und_q;
`else
    assign overflow = 1'b0;
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_usb_burst_cache.sv
// Scoreboard bench for usb_burst_cache: a queue-based cache model predicts
// every playout slot; a monitor pops and compares the DUT outputs.
module tb_usb_burst_cache;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 8;
    localparam int BURST_LEN = 255;
    localparam int NUM_CH    = 16;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              usb_flag;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [NUM_CH-1:0] wren_for_ram;
    logic [ADDR_W:0]   fill_level;
    logic              busy;
    logic              overflow;
    logic              underrun;

    usb_burst_cache #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .NUM_CH    (NUM_CH)
    ) dut (
        .clock        (clk),
        .rst_n        (rst_n),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .usb_flag     (usb_flag),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .wren_for_ram (wren_for_ram),
        .fill_level   (fill_level),
        .busy         (busy),
        .overflow     (overflow),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] d;
    } exp_t;

    exp_t              expq[$];
    logic [DATA_W-1:0] cache[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int                m_slots = 0;
    bit                m_done  = 0;
    bit                f1 = 1, f2 = 1, f3 = 1;
    logic [DATA_W-1:0] m_last = '0;
    bit                m_ovf = 0;
    bit                m_und = 0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    // Model: a burst starts once the flag history shows a 1 then a 0
    // seen two edges back; each slot pops the oldest word if any.
    always @(posedge clk) begin : model
        bit                rd;
        bit                fall_now;
        logic [DATA_W-1:0] d;
        rd = 0;
        d  = '0;
        if (!rst_n) begin
            cache.delete();
            m_slots = 0;
            m_done  = 0;
            f1 = 1; f2 = 1; f3 = 1;
            m_last = '0;
            m_ovf  = 0;
            m_und  = 0;
        end else begin
            fall_now = f3 && !f2;
            f3 = f2; f2 = f1; f1 = usb_flag;
            if (m_slots > 0) begin
                if (cache.size() > 0) begin
                    rd = 1;
                    d  = cache.pop_front();
                    m_last = d;
                end else begin
                    m_und = 1;
                end
                expq.push_back('{v: rd, d: m_last});
                m_slots--;
                if (m_slots == 0) m_done = 1;
            end else if (m_done) begin
                m_done = 0;
            end else if (fall_now) begin
                m_slots = BURST_LEN;
            end
            if (wr_en) begin
                if (cache.size() < DEPTH) cache.push_back(wr_data);
                else m_ovf = 1;
            end
        end
    end

    always begin : monitor
        exp_t e;
        bit   eo, eu;
        @(posedge clk);
        #1;
        if (wren_for_ram != '0 || rd_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_slot", {48'd0, wren_for_ram}, 64'd0);
            end else begin
                e = expq.pop_front();
                chk("wren", {48'd0, wren_for_ram}, 64'hffff);
                chk("rd_valid", {63'd0, rd_valid}, {63'd0, e.v});
                chk("rd_data", {32'd0, rd_data}, {32'd0, e.d});
            end
        end else if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("missing_slot", {48'd0, wren_for_ram}, 64'hffff);
        end
        chk("fill_level", {55'd0, fill_level}, 64'(cache.size()));
        chk("busy", {63'd0, busy}, {63'd0, (m_slots > 0 || m_done)});
`ifdef CACHE_STATUS_EN
        eo = m_ovf;
        eu = m_und;
`else
        eo = 0;
        eu = 0;
`endif
        chk("overflow", {63'd0, overflow}, {63'd0, eo});
        chk("underrun", {63'd0, underrun}, {63'd0, eu});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic write_seq(input int n, input logic [DATA_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = base + DATA_W'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_flag(input int low);
        @(negedge clk);
        usb_flag = 1'b0;
        repeat (low) @(negedge clk);
        usb_flag = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (6) @(negedge clk);
        while ((m_slots > 0 || m_done) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL burst_timeout actual=%0d required<2000", n);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        usb_flag = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // 10 words then a burst: 10 valid, 245 underrun slots
        write_seq(10, 32'h100);
        idle(2);
        pulse_flag(4);
        wait_idle();

        // Fill to 256, then one dropped word
        write_seq(256, 32'h0);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 32'hdead;
        @(negedge clk);
        wr_en = 1'b0;
        idle(2);
        pulse_flag(3);
        wait_idle();

        // Refill to full, write every cycle across a whole burst
        write_seq(DEPTH - 1, 32'h1000);
        idle(1);
        for (int i = 0; i < 280; i++) begin
            @(negedge clk);
            wr_en    = 1'b1;
            wr_data  = $urandom;
            usb_flag = (i < 3) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle();

        // Second fall mid-burst is ignored
        write_seq(40, 32'h2000);
        pulse_flag(3);
        repeat (60) @(negedge clk);
        pulse_flag(4);
        wait_idle();
        idle(20);

        // Reset mid-burst, then a burst over an empty cache
        write_seq(200, 32'h3000);
        pulse_flag(3);
        repeat (101) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        pulse_flag(3);
        wait_idle();

        // Random traffic with random flag pulses
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            wr_en    = ($urandom_range(0, 3) != 0);
            wr_data  = $urandom;
            usb_flag = ($urandom_range(0, 60) == 0) ? 1'b0 : usb_flag;
            if (!usb_flag && $urandom_range(0, 2) == 0) usb_flag = 1'b1;
        end
        usb_flag = 1'b1;
        wr_en    = 1'b0;
        wait_idle();

        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL leftover_slots actual=%0d required=0",
                     expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
